pma_tx_scheduler: RTL
=====================

Name: pma_tx_scheduler

Overview:
Symbol-level controller that sequences the 10-bit PMA serializer.
- Runs on the bit clock and decides, once per symbol slot (every DATA_WIDTH bit clocks), which symbol is loaded into the serializer.
- Arbitrates between periodic SKP insertion, an ordered-set injector and the encoded data path; fills empty slots with an idle symbol.
- Sits between the 8b/10b encoder / ordered-set logic and the PMA serializer.

Parameters:
- DATA_WIDTH, 10, symbol width in bits; also the slot length in bit clocks.
- SKP_INTERVAL, 16, number of symbols emitted in RUN before a SKP burst becomes pending (minimum 2).
- SKP_LEN, 2, number of consecutive SKP symbols per burst (minimum 1).
- IDLE_SYM, 10'h17C, filler symbol used when no requester is ready.
- SKP_SYM, 10'h2BC, skip symbol.

Ports:
- Bit_Rate_10  in  1  bit clock; all logic on rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- Tx_En  in  1  link transmit enable.
- Data_Valid  in  1  data symbol available.
- Data_Sym  in  DATA_WIDTH  data symbol.
- Data_Ready  out  1  data symbol consumed this cycle (combinational).
- OS_Req  in  1  ordered-set symbol request; held until acked.
- OS_Sym  in  DATA_WIDTH  ordered-set symbol.
- OS_Ack  out  1  ordered-set symbol consumed this cycle (combinational).
- Sym_Out  out  DATA_WIDTH  symbol to serializer (registered).
- Sym_Load  out  1  one-cycle load strobe to serializer (registered).
- Tx_Active  out  1  high in RUN or SKIP.
- Idle_Fill_Cnt  out  16  idle-fill statistic (see Optional Feature).

Behaviour:
- Reset values: state = IDLE, slot counter = 0, SKP timer = 0, skp_pending = 0, SKP burst count = 0, Sym_Out = 0, Sym_Load = 0, Tx_Active = 0, Idle_Fill_Cnt = 0.
- Reset asserted mid-symbol clears everything immediately. Any partially scheduled symbol is dropped.
- Slot counter: width $clog2(DATA_WIDTH). Counts 0..DATA_WIDTH-1 in RUN/SKIP and wraps to 0. Held at 0 in IDLE. A "boundary" is any cycle with slot counter = 0 in RUN or SKIP.
- IDLE:
  - Tx_En = 1 moves to RUN on the next edge.
  - The first boundary is the first RUN cycle.
  - Data_Ready, OS_Ack and Sym_Load are all 0.
- At a boundary with Tx_En = 1, exactly one symbol is selected. Priority, highest first:
  1. In SKIP, or skp_pending: SKP_SYM.
  2. OS_Req: OS_Sym, with OS_Ack = 1.
  3. Data_Valid: Data_Sym, with Data_Ready = 1.
  4. Otherwise IDLE_SYM.
- Data_Ready and OS_Ack are high only in the boundary cycle and are never high together.
- Latency: the symbol selected in boundary cycle N appears on Sym_Out with Sym_Load = 1 in cycle N+1.
  - Sym_Out holds its value until the next load.
  - Sym_Load is high for exactly one cycle per DATA_WIDTH cycles.
- SKP timer:
  - Increments on each non-SKP symbol emitted in RUN.
  - When it reaches SKP_INTERVAL, skp_pending is set and the timer is cleared.
  - At the next boundary the block enters SKIP and emits SKP_LEN SKP symbols on consecutive boundaries, then returns to RUN and clears skp_pending.
  - The timer does not count during SKIP.
- Tx_En low at a boundary: the previous symbol has fully shifted out.
  - The block goes to IDLE with no load.
  - SKP timer, skp_pending and burst count are cleared, aborting any SKIP burst.
- Tx_En low between boundaries: the current slot completes, then the block stops at the next boundary.
- Simultaneous OS_Req and Data_Valid: the ordered set wins. Data waits with no ack.
- OS_Req present while skp_pending is set: deferred until the SKP burst completes.
- Tx_Active is 1 in RUN and SKIP, 0 in IDLE.

Optional Feature:
- Macro: PMA_TX_SCHED_STATS_EN.
- Defined:
  - Idle_Fill_Cnt increments by 1 each time IDLE_SYM is selected while Tx_En = 1.
  - Saturates at 16'hFFFF.
  - Cleared only by Rst_n.
- Undefined: Idle_Fill_Cnt is tied to 0 and no counter logic is built.

Test Plan:
- Reset then Tx_En = 1 with Data_Valid = 1 and Data_Sym = 10'h155 held -> Data_Ready pulses on the first RUN cycle. Sym_Load = 1 with Sym_Out = 10'h155 one cycle later. Loads repeat every 10 cycles.
- OS_Req and Data_Valid both high at a boundary, OS_Sym = 10'h0F8 -> OS_Ack = 1 and Data_Ready = 0. Next load carries 10'h0F8. The data symbol goes out on the following slot.
- SKP_INTERVAL = 4, SKP_LEN = 2, continuous data -> symbols 5 and 6 are 10'h2BC. No Data_Ready during those boundaries. Data resumes at symbol 7.
- Tx_En = 1 with no requesters -> every load is 10'h17C. With the macro defined, Idle_Fill_Cnt = 3 after three loads.
- Tx_En dropped at slot 4 -> the slot completes. At the next boundary: state IDLE, no further Sym_Load, Tx_Active = 0.
- Rst_n pulsed low at slot 6 during a SKP burst -> all outputs are 0 immediately. After release with Tx_En = 1, the first load is a data or idle symbol, not SKP.

Source files
------------

// File: rtl/pma_tx_scheduler_if.sv
// Symbol-source / serializer-side bundle of the PMA transmit scheduler.
interface pma_tx_scheduler_if #(
  parameter int DATA_WIDTH = 10
);
  logic                  Tx_En;
  logic                  Data_Valid;
  logic [DATA_WIDTH-1:0] Data_Sym;
  logic                  Data_Ready;
  logic                  OS_Req;
  logic [DATA_WIDTH-1:0] OS_Sym;
  logic                  OS_Ack;
  logic [DATA_WIDTH-1:0] Sym_Out;
  logic                  Sym_Load;
  logic                  Tx_Active;
  logic [15:0]           Idle_Fill_Cnt;

  modport master (
    output Tx_En, Data_Valid, Data_Sym, OS_Req, OS_Sym,
    input  Data_Ready, OS_Ack, Sym_Out, Sym_Load, Tx_Active, Idle_Fill_Cnt
  );

  modport slave (
    input  Tx_En, Data_Valid, Data_Sym, OS_Req, OS_Sym,
    output Data_Ready, OS_Ack, Sym_Out, Sym_Load, Tx_Active, Idle_Fill_Cnt
  );
endinterface

// File: rtl/pma_tx_scheduler.sv
// Per-slot symbol picker for the 10-bit PMA serializer: SKP > ordered set > data > idle.
// Optional idle-fill statistic enabled by defining PMA_TX_SCHED_STATS_EN.
module pma_tx_scheduler #(
  parameter int                    DATA_WIDTH   = 10,
  parameter int                    SKP_INTERVAL = 16,
  parameter int                    SKP_LEN      = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_SYM     = DATA_WIDTH'(10'h17C),
  parameter logic [DATA_WIDTH-1:0] SKP_SYM      = DATA_WIDTH'(10'h2BC)
) (
  input  logic              Bit_Rate_10,
  input  logic              Rst_n,
  pma_tx_scheduler_if.slave bus
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int TW = $clog2(SKP_INTERVAL + 1);
  localparam int BW = $clog2(SKP_LEN + 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(DATA_WIDTH - 1);
  localparam logic [TW-1:0] TMR_LAST   = TW'(SKP_INTERVAL - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(SKP_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SKIP} state_t;

  state_t          state;
  logic [CW-1:0]   slot;
  logic [TW-1:0]   skp_tmr;
  logic            skp_pending;
  logic [BW-1:0]   burst;

  logic                  boundary, go, skp_sel, os_sel, data_sel, idle_sel;
  logic [DATA_WIDTH-1:0] sel_sym;

  always_comb begin
    boundary = (state != S_IDLE) && (slot == '0);
    go       = boundary && bus.Tx_En;
    skp_sel  = go && ((state == S_SKIP) || skp_pending);
    os_sel   = go && !skp_sel && bus.OS_Req;
    data_sel = go && !skp_sel && !bus.OS_Req && bus.Data_Valid;
    idle_sel = go && !skp_sel && !bus.OS_Req && !bus.Data_Valid;
    sel_sym  = IDLE_SYM;
    if (skp_sel)       sel_sym = SKP_SYM;
    else if (os_sel)   sel_sym = bus.OS_Sym;
    else if (data_sel) sel_sym = bus.Data_Sym;
  end

  assign bus.Data_Ready = data_sel;
  assign bus.OS_Ack     = os_sel;
  assign bus.Tx_Active  = (state != S_IDLE);

  always_ff @(posedge Bit_Rate_10 or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= S_IDLE;
      slot         <= '0;
      skp_tmr      <= '0;
      skp_pending  <= 1'b0;
      burst        <= '0;
      bus.Sym_Out  <= '0;
      bus.Sym_Load <= 1'b0;
    end else begin
      bus.Sym_Load <= 1'b0;
      case (state)
        S_IDLE: begin
          slot <= '0;
          if (bus.Tx_En) state <= S_RUN;
        end
        default: begin
          slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
          if (boundary && !bus.Tx_En) begin
            // previous symbol is fully shifted out; abort any SKP burst
            state       <= S_IDLE;
            slot        <= '0;
            skp_tmr     <= '0;
            skp_pending <= 1'b0;
            burst       <= '0;
          end else if (go) begin
            bus.Sym_Load <= 1'b1;
            bus.Sym_Out  <= sel_sym;
            if (skp_sel) begin
              if (burst == BURST_LAST) begin
                burst       <= '0;
                skp_pending <= 1'b0;
                state       <= S_RUN;
              end else begin
                burst <= burst + 1'b1;
                state <= S_SKIP;
              end
            end else if (skp_tmr == TMR_LAST) begin
              skp_tmr     <= '0;
              skp_pending <= 1'b1;
            end else begin
              skp_tmr <= skp_tmr + 1'b1;
            end
          end
        end
      endcase
    end
  end

`ifdef PMA_TX_SCHED_STATS_EN
  logic [15:0] idle_cnt;
  always_ff @(posedge Bit_Rate_10 or negedge Rst_n) begin
    if (!Rst_n)                             idle_cnt <= '0;
    else if (idle_sel && idle_cnt != 16'hFFFF) idle_cnt <= idle_cnt + 16'd1;
  end
  assign bus.Idle_Fill_Cnt = idle_cnt;
`else
  assign bus.Idle_Fill_Cnt = '0;
`endif
endmodule
